// File: rtl/flop_enable_reset.sv
// rtl/flop_enable_reset.sv - load-enable register with async reset, plus mux2/mux4 helpers
// Datapath primitives: mux port order is fixed so parents can instantiate positionally.

module flop_enable_reset #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset wins over the clock and drops any load that would have happened.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

module mux2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

module mux4 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);

    assign y = s[1] ? (s[0] ? d3 : d2) : (s[0] ? d1 : d0);

endmodule

// File: tb/tb_flop_enable_reset.sv
// tb/tb_flop_enable_reset.sv - self-checking bench for flop_enable_reset, mux2 and mux4

module tb_flop_enable_reset;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] d;
    logic [15:0] q;

    logic        reset8;
    logic        enable8;
    logic [7:0]  d8;
    logic [7:0]  q8;

    logic [15:0] m2_d0, m2_d1, m2_y;
    logic        m2_s;
    logic [15:0] m4_d0, m4_d1, m4_d2, m4_d3, m4_y;
    logic [1:0]  m4_s;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    flop_enable_reset #(.WIDTH(16)) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .d      (d),
        .q      (q)
    );

    flop_enable_reset dut8 (
        .clock  (clock),
        .reset  (reset8),
        .enable (enable8),
        .d      (d8),
        .q      (q8)
    );

    mux2 #(16) u_mux2 (m2_d0, m2_d1, m2_s, m2_y);
    mux4 #(16) u_mux4 (m4_d0, m4_d1, m4_d2, m4_d3, m4_s, m4_y);

    typedef struct {
        logic        rst;
        logic        en;
        logic [15:0] din;
        logic [15:0] exp_q;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic edge_sample();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] ref_q;
        logic [15:0] ins[4];

        vecs[0] = '{1'b1, 1'b1, 16'hFFFF, 16'h0000};
        vecs[1] = '{1'b0, 1'b1, 16'h1234, 16'h1234};
        vecs[2] = '{1'b0, 1'b0, 16'h5678, 16'h1234};
        vecs[3] = '{1'b0, 1'b0, 16'h5678, 16'h1234};
        vecs[4] = '{1'b0, 1'b0, 16'h5678, 16'h1234};
        vecs[5] = '{1'b0, 1'b1, 16'h5678, 16'h5678};
        vecs[6] = '{1'b1, 1'b0, 16'h9999, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 16'hAAAA, 16'h0000};
        vecs[8] = '{1'b0, 1'b1, 16'hAAAA, 16'hAAAA};

        reset = 1'b1; enable = 1'b0; d = 16'h0;
        reset8 = 1'b1; enable8 = 1'b0; d8 = 8'h0;
        m2_d0 = 16'h0; m2_d1 = 16'h0; m2_s = 1'b0;
        m4_d0 = 16'h0; m4_d1 = 16'h0; m4_d2 = 16'h0; m4_d3 = 16'h0; m4_s = 2'b00;

        #2;
        check("reset_state", q, 16'h0000);
        check("reset_state8", {8'h00, q8}, 16'h0000);

        // Inputs change on the falling edge so reset release never races a rising edge.
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            reset = vecs[i].rst; enable = vecs[i].en; d = vecs[i].din;
            edge_sample();
            check($sformatf("vec%0d", i), q, vecs[i].exp_q);
        end

        // Asynchronous clear between edges.
        @(negedge clock);
        reset = 1'b0; enable = 1'b1; d = 16'hBEEF;
        edge_sample();
        check("load_beef", q, 16'hBEEF);
        enable = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("async_clear", q, 16'h0000);

        // Reset dominates enable across edges, then first edge after release loads.
        enable = 1'b1; d = 16'hFFFF;
        edge_sample();
        check("rst_hold_edge1", q, 16'h0000);
        edge_sample();
        check("rst_hold_edge2", q, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("release_no_edge", q, 16'h0000);
        edge_sample();
        check("first_load_after_release", q, 16'hFFFF);

        // Default-width instance.
        @(negedge clock);
        reset8 = 1'b0; enable8 = 1'b1; d8 = 8'hFF;
        edge_sample();
        check("w8_load_ff", {8'h00, q8}, 16'h00FF);
        #2;
        reset8 = 1'b1;
        #1;
        check("w8_reset", {8'h00, q8}, 16'h0000);

        // Randomized run against a reference register; reset asserted mid-cycle is checked immediately.
        ref_q = q;
        for (int n = 0; n < 300; n++) begin
            @(negedge clock);
            reset  = ($urandom_range(0, 9) == 0);
            enable = $urandom_range(0, 1);
            d      = $urandom;
            #1;
            if (reset) begin
                ref_q = 16'h0000;
                check("rand_async", q, ref_q);
            end
            edge_sample();
            if (!reset && enable) ref_q = d;
            check("rand_q", q, ref_q);
        end

        // mux2 directed.
        m2_d0 = 16'hAAAA; m2_d1 = 16'h5555; m2_s = 1'b0;
        #1 check("mux2_s0", m2_y, 16'hAAAA);
        m2_s = 1'b1;
        #1 check("mux2_s1", m2_y, 16'h5555);

        // mux4 sweep, then an input change with no clock involvement.
        m4_d0 = 16'h0001; m4_d1 = 16'h0002; m4_d2 = 16'h0003; m4_d3 = 16'h0004;
        for (int s = 0; s < 4; s++) begin
            m4_s = s[1:0];
            #1 check($sformatf("mux4_s%0d", s), m4_y, 16'(s + 1));
        end
        m4_s = 2'd2;
        #1;
        m4_d2 = 16'h00AA;
        #1 check("mux4_d2_change", m4_y, 16'h00AA);

        // Random mux checks against an indexed-array model.
        for (int n = 0; n < 40; n++) begin
            m2_d0 = $urandom; m2_d1 = $urandom; m2_s = $urandom_range(0, 1);
            ins[0] = $urandom; ins[1] = $urandom; ins[2] = $urandom; ins[3] = $urandom;
            m4_d0 = ins[0]; m4_d1 = ins[1]; m4_d2 = ins[2]; m4_d3 = ins[3];
            m4_s = 2'($urandom_range(0, 3));
            #1;
            check("rand_mux2", m2_y, m2_s ? m2_d1 : m2_d0);
            check("rand_mux4", m4_y, ins[m4_s]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
